decoder_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 3-to-8 decoder select path among 8 requesters.
- It picks one requester, holds the grant for a bounded time, then rotates priority to the next requester.
- It drives the decoder select lines (sel_a = LSB, sel_b, sel_c = MSB) and a registered one-hot grant that matches decoder outputs d0..d7.
- It sits between the requesting agents and the decoder instance.

---
 rtl/decoder_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter.sv
`default_nettype none
// =============================================================================
// decoder_rr_arbiter - round-robin arbiter sharing one 3-to-8 decoder select path
// Revision 1.0
// =============================================================================
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    input  logic       done_i,
    output logic       sel_a_o,
    output logic       sel_b_o,
    output logic       sel_c_o,
    output logic       gnt_valid_o,
    output logic [7:0] gnt_onehot_o,
    output logic       timeout_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_BAD     = 2'd3;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]       onehot_q, onehot_d;
    logic             timeout_q, timeout_d;

    logic [2:0]       pick;
    logic             release_early;
    logic             expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 3'd0;
            idx_q      <= 3'd0;
            hold_cnt_q <= '0;
            onehot_q   <= 8'h00;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            onehot_q   <= onehot_d;
            timeout_q  <= timeout_d;
        end
    end

    // Scan downward so the lowest rotated offset from ptr is the final winner.
    always_comb begin
        pick = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            if (req_i[ptr_q + 3'(k)]) begin
                pick = ptr_q + 3'(k);
            end
        end
    end

    assign release_early = done_i || !req_i[idx_q];
    assign expire        = (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        onehot_d   = onehot_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d    = ST_GRANT;
                    idx_d      = pick;
                    hold_cnt_d = '0;
                    onehot_d   = 8'b1 << pick;
                end
            end
            ST_GRANT: begin
                if (release_early) begin
                    state_d  = ST_RELEASE;
                    onehot_d = 8'h00;
                end else if (expire) begin
                    state_d   = ST_RELEASE;
                    onehot_d  = 8'h00;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                ptr_d    = idx_q + 3'd1;
                onehot_d = 8'h00;
            end
            default: begin
                state_d    = ST_IDLE;
                idx_d      = 3'd0;
                hold_cnt_d = '0;
                onehot_d   = 8'h00;
            end
        endcase
    end

    always_comb begin
        gnt_valid_o  = (state_q == ST_GRANT);
        gnt_onehot_o = (state_q == ST_BAD) ? 8'h00 : onehot_q;
        timeout_o    = (state_q == ST_BAD) ? 1'b0  : timeout_q;
        {sel_c_o, sel_b_o, sel_a_o} = (state_q == ST_BAD) ? 3'd0 : idx_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
`default_nettype none
// =============================================================================
// tb_decoder_rr_arbiter - vector table, directed corner cases and random model check
// Revision 1.0
// =============================================================================
module tb_decoder_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = 8'h00;
    logic       done  = 1'b0;
    logic       sel_a, sel_b, sel_c, gnt_valid, timeout;
    logic [7:0] gnt_onehot;
    logic [12:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    decoder_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .done_i      (done),
        .sel_a_o     (sel_a),
        .sel_b_o     (sel_b),
        .sel_c_o     (sel_c),
        .gnt_valid_o (gnt_valid),
        .gnt_onehot_o(gnt_onehot),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    // {gnt_valid, gnt_onehot, sel, timeout}
    assign obs = {gnt_valid, gnt_onehot, sel_c, sel_b, sel_a, timeout};

    function automatic logic [12:0] pk(bit v, logic [7:0] oh, int s, bit to);
        return {v, oh, 3'(s), to};
    endfunction

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h (v,oh,sel,to) expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        req   = 8'h00;
        done  = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Reference model: grant age, dead-cycle flag and rotating pointer
    bit m_valid, m_dead, m_to;
    int m_idx, m_age, m_ptr;

    task automatic m_reset();
        m_valid = 0; m_dead = 0; m_to = 0;
        m_idx = 0; m_age = 0; m_ptr = 0;
    endtask

    task automatic m_step(input logic [7:0] r, input bit d);
        bit found;
        if (m_valid) begin
            m_valid = 0;
            m_dead  = 1;
            m_to    = 0;
            if (!(d || !r[m_idx])) begin
                if (m_age == MAX_HOLD) begin
                    m_to = 1;
                end else begin
                    m_valid = 1;
                    m_dead  = 0;
                    m_age++;
                end
            end
        end else if (m_dead) begin
            m_dead = 0;
            m_to   = 0;
            m_ptr  = (m_idx + 1) % 8;
        end else begin
            m_to  = 0;
            found = 0;
            for (int k = 0; k < 8; k++) begin
                if (!found && r[(m_ptr + k) % 8]) begin
                    m_idx = (m_ptr + k) % 8;
                    found = 1;
                end
            end
            if (found) begin
                m_valid = 1;
                m_age   = 1;
            end
        end
    endtask

    function automatic logic [12:0] m_exp();
        return pk(m_valid, m_valid ? 8'(1 << m_idx) : 8'h00, m_idx, m_to);
    endfunction

    typedef struct {
        logic [7:0]  req;
        bit          done;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[20];

    task automatic setv(input int i, input logic [7:0] r, input bit d, input logic [12:0] e);
        tbl[i].req  = r;
        tbl[i].done = d;
        tbl[i].exp  = e;
    endtask

    initial begin
        setv(0,  8'h20, 0, pk(1, 8'h20, 5, 0));
        setv(1,  8'h20, 0, pk(1, 8'h20, 5, 0));
        setv(2,  8'h20, 0, pk(1, 8'h20, 5, 0));
        setv(3,  8'h20, 1, pk(0, 8'h00, 5, 0));
        setv(4,  8'h20, 0, pk(0, 8'h00, 5, 0));
        setv(5,  8'h20, 0, pk(1, 8'h20, 5, 0));
        setv(6,  8'h00, 0, pk(0, 8'h00, 5, 0));
        setv(7,  8'h00, 0, pk(0, 8'h00, 5, 0));
        setv(8,  8'h08, 0, pk(1, 8'h08, 3, 0));
        setv(9,  8'h08, 0, pk(1, 8'h08, 3, 0));
        setv(10, 8'h08, 0, pk(1, 8'h08, 3, 0));
        setv(11, 8'h08, 0, pk(1, 8'h08, 3, 0));
        setv(12, 8'h08, 0, pk(0, 8'h00, 3, 1));
        setv(13, 8'h08, 0, pk(0, 8'h00, 3, 0));
        setv(14, 8'h08, 0, pk(1, 8'h08, 3, 0));
        setv(15, 8'h08, 0, pk(1, 8'h08, 3, 0));
        setv(16, 8'h08, 0, pk(1, 8'h08, 3, 0));
        setv(17, 8'h08, 0, pk(1, 8'h08, 3, 0));
        setv(18, 8'h08, 1, pk(0, 8'h00, 3, 0));
        setv(19, 8'h08, 0, pk(0, 8'h00, 3, 0));

        // Reset held with all requests asserted
        rst_n = 1'b0; req = 8'hFF; done = 1'b0;
        repeat (2) tick();
        chk("reset_outputs", obs, pk(0, 8'h00, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("first_grant_after_reset", obs, pk(1, 8'h01, 0, 0));

        // Single requester, re-grant, then timeout and done-at-expiry
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            tick();
            chk($sformatf("vec%0d", i), obs, tbl[i].exp);
        end

        // Full rotation with one-cycle grants
        apply_reset();
        req = 8'hFF; done = 1'b1;
        for (int g = 0; g < 9; g++) begin
            tick();
            chk($sformatf("rot_grant%0d", g), obs, pk(1, 8'(1 << (g % 8)), g % 8, 0));
            tick();
            chk($sformatf("rot_release%0d", g), obs, pk(0, 8'h00, g % 8, 0));
            tick();
            chk($sformatf("rot_idle%0d", g), obs, pk(0, 8'h00, g % 8, 0));
        end

        // Wrap-around from ptr 7
        apply_reset();
        req = 8'h40; done = 1'b1;
        tick();
        chk("wrap_grant6", obs, pk(1, 8'h40, 6, 0));
        req = 8'h22;
        repeat (3) tick();
        chk("wrap_grant1", obs, pk(1, 8'h02, 1, 0));
        repeat (3) tick();
        chk("wrap_grant5", obs, pk(1, 8'h20, 5, 0));
        repeat (3) tick();
        chk("wrap_grant1_again", obs, pk(1, 8'h02, 1, 0));

        // Asynchronous reset in the middle of a grant
        done = 1'b0; req = 8'hFF;
        tick();
        chk("midgrant_hold", obs, pk(1, 8'h02, 1, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_midgrant", obs, pk(0, 8'h00, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("grant_after_midreset", obs, pk(1, 8'h01, 0, 0));

        // Random traffic against the reference model
        apply_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = 8'h00;
                    1: req = 8'(1 << $urandom_range(0, 7));
                    default: req = 8'($urandom);
                endcase
            end
            done = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                m_reset();
                #1;
                chk("rand_reset", obs, m_exp());
                #2;
                rst_n = 1'b1;
            end else begin
                m_step(req, done);
                tick();
                chk($sformatf("rand_cycle%0d", c), obs, m_exp());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
